// File: rtl/xcvr_link_supervisor.sv
// Transceiver link supervisor.
// Drives the reset input of the transceiver reset controller: issues a reset
// pulse, waits for tx_ready/rx_ready/lock under a watchdog, retries a bounded
// number of times, and re-initiates reset after a filtered loss of link.
module xcvr_link_supervisor #(
  parameter int unsigned RESET_PULSE_CYCLES   = 16,
  parameter int unsigned READY_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned LOSS_FILTER_CYCLES   = 64,
  parameter int unsigned MAX_RETRIES          = 7,
  parameter int unsigned CNT_W                = 24
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       force_reset,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic       rx_is_lockedtodata,
  output logic       xcvr_reset,
  output logic       link_up,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] relink_count,
  output logic       timeout_pulse
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_READY,
    ST_LINK_UP,
    ST_FAIL
  } state_t;

  // Terminal values of the shared counter in each state that uses it.
  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_d, retry_inc;
  logic [7:0]       relink_d;
  logic             timeout_d;
  logic             lock_meta, lock_s;
  logic             good;

  // Two-flop synchronizer for the asynchronous PHY lock indication.
  // NOTE: sequential logic uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= rx_is_lockedtodata;
      lock_s    <= lock_meta;
    end
  end

  assign good = tx_ready & rx_ready & lock_s;

  // A failed attempt never pushes the retry count past its limit, even when an
  // attempt started from IDLE after FAIL already recorded the maximum.
  assign retry_inc = (retry_count >= RETRY_MAX) ? RETRY_MAX : retry_count + 4'd1;

  // Next-state, counter and event decode; enable and force_reset override the
  // per-state rules.
  // NOTE: every signal assigned here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_count;
    relink_d  = relink_count;
    timeout_d = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (force_reset && (state_q != ST_IDLE)) begin
      state_d = ST_RESET;
      cnt_d   = PULSE_LOAD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RESET;
          cnt_d   = PULSE_LOAD;
        end
        ST_RESET: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_WAIT_READY: begin
          if (good) begin
            state_d = ST_LINK_UP;
            cnt_d   = '0;
            retry_d = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            timeout_d = 1'b1;
            retry_d   = retry_inc;
            if (retry_inc == RETRY_MAX) begin
              state_d = ST_FAIL;
              cnt_d   = '0;
            end else begin
              state_d = ST_RESET;
              cnt_d   = PULSE_LOAD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LINK_UP: begin
          if (good) begin
            cnt_d = '0;
          end else if (cnt_q == LOSS_LAST) begin
            state_d  = ST_RESET;
            cnt_d    = PULSE_LOAD;
            relink_d = (relink_count == 8'hFF) ? relink_count : relink_count + 8'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; the decoded outputs follow the
  // next state so they change on the same edge as the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      retry_count   <= '0;
      relink_count  <= '0;
      timeout_pulse <= 1'b0;
      xcvr_reset    <= 1'b1;
      link_up       <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_count   <= retry_d;
      relink_count  <= relink_d;
      timeout_pulse <= timeout_d;
      xcvr_reset    <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
      link_up       <= (state_d == ST_LINK_UP);
      fail          <= (state_d == ST_FAIL);
    end
  end

endmodule
